spi_slave_rx: RTL and testbench

SPI slave receiver; the receive end of the team's SPI master transmitter link. Oversamples SCK, MOSI and SS_n in the system clock domain and deserialises N-bit words MSB-first in SPI mode 0 (sample on SCK rising edge). Presents each word on a valid/ready stream interface and flags overrun and truncated frames.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/sync_ff.sv | 24 ++
 rtl/spi_slave_rx.sv | 113 +++++++++++
 tb/tb_spi_slave_rx.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master/slave link.
package spi_pkg;

    localparam int SPI_WORD_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        RECV
    } spi_rx_state_t;

    // Master transmitter states, kept here so both ends of the link share one package.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SHIFT,
        TX_DONE
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit flop-chain synchroniser with async active-low reset to a chosen idle level.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversampled SCK/MOSI/SS_n, MSB-first N-bit words on a valid/ready stream.
//
// state | meaning
// IDLE  | slave not selected; SCK edges ignored
// RECV  | ss_n low; shifting MOSI on each synchronised SCK rise
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int N           = SPI_WORD_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sck,
    input  logic         mosi,
    input  logic         ss_n,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         overrun,
    output logic         frame_err,
    output logic         busy
);

    localparam int CW = $clog2(N);

    logic          sck_s, mosi_s, ss_n_s, sck_prev;
    logic          sck_rise, sample, word_done, accept, abort;
    logic [N-1:0]  shift_reg, word_next;
    logic [CW-1:0] bit_cnt;
    spi_rx_state_t state, state_d;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d(sck), .q(sck_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_n_s)
    );

    assign sck_rise  = sck_s & ~sck_prev;
    assign word_done = sample && (bit_cnt == CW'(N-1));
    assign word_next = {shift_reg[N-2:0], mosi_s};
    assign accept    = data_valid && data_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ss_n release outranks a coincident SCK rise, so a deselect never completes a word.
    always_comb begin
        state_d = state;
        sample  = 1'b0;
        abort   = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_n_s) state_d = RECV;
            end
            RECV: begin
                busy = 1'b1;
                if (ss_n_s) begin
                    state_d = IDLE;
                    abort   = (bit_cnt != '0);
                end else begin
                    sample = sck_rise;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_prev   <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sck_prev  <= sck_s;
            frame_err <= abort;
            if (state != RECV) begin
                bit_cnt <= '0;
            end else if (sample) begin
                bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
            end
            if (sample) shift_reg <= word_next;
            // A word landing while the consumer stalls is dropped; the held word wins.
            if (word_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word_next;
                    data_valid <= 1'b1;
                    if (accept) overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: queued expected words popped by a handshake monitor.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         sck = 1'b0;
    logic         mosi = 1'b0;
    logic         ss_n = 1'b1;
    logic         data_ready = 1'b0;
    logic [N-1:0] data_out;
    logic         data_valid, overrun, frame_err, busy;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;
    logic [N-1:0] exp_q[$];

    spi_slave_rx #(.N(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sck(sck), .mosi(mosi), .ss_n(ss_n),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen here completes on the coming rising edge.
    always @(negedge clk) begin
        logic [N-1:0] e;
        if (frame_err) fe_cnt++;
        if (reset_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
                e = exp_q.pop_front();
                chk("word", 32'(data_out), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        ticks(4);
        sck = 1'b1;
        ticks(4);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [N-1:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) spi_bit(w[N-1-i]);
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit push);
        if (push) exp_q.push_back(w);
        send_bits(w, N);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            tick();
            k++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int fe0;
        int nw;
        logic [N-1:0] w;

        // Reset values
        ticks(3);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        ticks(3);

        // Single word with latency check
        ss_n = 1'b0;
        ticks(4);
        chk("busy_recv", 32'(busy), 32'd1);
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 7);
        mosi = 1'b1;
        ticks(4);
        sck = 1'b1;
        ticks(2);
        chk("latency_early", 32'(data_valid), 32'd0);
        tick();
        chk("latency_valid", 32'(data_valid), 32'd1);
        ticks(3);
        sck = 1'b0;
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        chk("single_data", 32'(data_out), 32'hA5);
        chk("single_overrun", 32'(overrun), 32'd0);
        chk("single_fe", 32'(fe_cnt), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);
        data_ready = 1'b1;
        tick();
        chk("single_consumed", 32'(data_valid), 32'd0);

        // Back-to-back words in one frame
        ss_n = 1'b0;
        ticks(4);
        send_word(8'h3C, 1'b1);
        send_word(8'hC3, 1'b1);
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        drain();
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_fe", 32'(fe_cnt), 32'd0);

        // Overrun: second word dropped while the first is held
        data_ready = 1'b0;
        ss_n = 1'b0;
        ticks(4);
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b0);
        ticks(6);
        chk("ovr_data", 32'(data_out), 32'h11);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        ss_n = 1'b1;
        ticks(6);
        data_ready = 1'b1;
        ticks(2);
        chk("ovr_cleared", 32'(overrun), 32'd0);
        chk("ovr_valid_low", 32'(data_valid), 32'd0);
        drain();

        // Handshake coincides with completion
        data_ready = 1'b0;
        ss_n = 1'b0;
        ticks(4);
        send_word(8'h55, 1'b1);
        ticks(2);
        exp_q.push_back(8'hAA);
        send_bits(8'hAA, 7);
        mosi = 1'b0;
        ticks(4);
        sck = 1'b1;
        ticks(2);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        chk("sim_valid", 32'(data_valid), 32'd1);
        chk("sim_data", 32'(data_out), 32'hAA);
        chk("sim_overrun", 32'(overrun), 32'd0);
        ticks(3);
        sck = 1'b0;
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        data_ready = 1'b1;
        drain();

        // Truncated frame, then a clean word
        fe0 = fe_cnt;
        ss_n = 1'b0;
        ticks(4);
        send_bits(8'hB0, 5);
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        chk("trunc_fe_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("trunc_no_valid", 32'(data_valid), 32'd0);
        chk("trunc_idle", 32'(busy), 32'd0);
        ss_n = 1'b0;
        ticks(4);
        send_word(8'hF0, 1'b1);
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        drain();

        // Async reset mid-word with a held word pending
        fe0 = fe_cnt;
        data_ready = 1'b0;
        ss_n = 1'b0;
        ticks(4);
        send_word(8'h5A, 1'b0);
        chk("pre_rst_valid", 32'(data_valid), 32'd1);
        send_bits(8'hC0, 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(data_valid), 32'd0);
        chk("arst_data", 32'(data_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_fe", 32'(frame_err), 32'd0);
        ss_n = 1'b1;
        ticks(2);
        reset_n = 1'b1;
        ticks(3);
        data_ready = 1'b1;
        ss_n = 1'b0;
        ticks(4);
        send_word(8'h81, 1'b1);
        ticks(4);
        ss_n = 1'b1;
        ticks(6);
        drain();
        chk("arst_no_fe", 32'(fe_cnt - fe0), 32'd0);

        // Randomised frames of random words, consumer always ready
        fe0 = fe_cnt;
        for (int f = 0; f < 6; f++) begin
            ss_n = 1'b0;
            ticks(4);
            nw = int'($urandom_range(1, 4));
            for (int j = 0; j < nw; j++) begin
                w = N'($urandom);
                send_word(w, 1'b1);
            end
            ticks(4);
            ss_n = 1'b1;
            ticks(int'($urandom_range(3, 8)));
        end
        drain();
        chk("rand_overrun", 32'(overrun), 32'd0);
        chk("rand_fe", 32'(fe_cnt - fe0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
